vm_change_dispenser: RTL and testbench

Coin-return end of the vending machine: the acceptor/datapath deposits coins in and requests change, and this block pays coins back out. It keeps nickel/dime/quarter inventory counters, which are incremented by deposit pulses and decremented by dispenses. It accepts a change amount in cents over a valid/ready handshake and emits one-cycle coin-eject pulses, greedy largest-coin-first. It then reports completion, and flags a shortfall when inventory cannot cover the amount.

---
 rtl/vm_change_dispenser.sv | 209 ++++++++++++++++++++
 tb/tb_vm_change_dispenser.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_change_dispenser.sv
// Coin-return change dispenser.
// Keeps nickel/dime/quarter inventory and pays a requested amount back
// greedily, largest coin first, one coin per SELECT/DISPENSE/GAP round.
// Finishes with a one-cycle done pulse; short flags an unpaid balance.
module vm_change_dispenser #(
  parameter int AMT_W = 9,
  parameter int CNT_W = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             nickel_in,
  input  logic             dime_in,
  input  logic             quarter_in,
  output logic             nickel_out,
  output logic             dime_out,
  output logic             quarter_out,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] quarter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_DISPENSE = 3'd2,
    S_GAP      = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  localparam logic [AMT_W-1:0] C_NICKEL   = AMT_W'(32'd5);
  localparam logic [AMT_W-1:0] C_DIME     = AMT_W'(32'd10);
  localparam logic [AMT_W-1:0] C_QUARTER  = AMT_W'(32'd25);
  localparam logic [AMT_W-1:0] C_AMT_ZERO = {AMT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       C_GAP      = 4'(GAP);

  state_t           r_state;
  logic [AMT_W-1:0] r_remaining;
  logic [3:0]       r_gap;
  logic             r_nickel_out;
  logic             r_dime_out;
  logic             r_quarter_out;
  logic             r_done;
  logic             r_short;
  logic [CNT_W-1:0] r_nickel_cnt;
  logic [CNT_W-1:0] r_dime_cnt;
  logic [CNT_W-1:0] r_quarter_cnt;

  state_t           w_state_nxt;
  logic [AMT_W-1:0] w_rem_nxt;
  logic [3:0]       w_gap_nxt;
  logic             w_nickel_out_nxt;
  logic             w_dime_out_nxt;
  logic             w_quarter_out_nxt;
  logic             w_done_nxt;
  logic             w_short_nxt;
  logic             w_ej_nickel;
  logic             w_ej_dime;
  logic             w_ej_quarter;

  // Inventory update: deposit saturates, eject never underflows (guarded at
  // SELECT), and a simultaneous deposit plus eject leaves the count alone.
  function automatic logic [CNT_W-1:0] f_inv_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             dec
  );
    logic [CNT_W-1:0] v;
    v = cnt;
    if (inc && !dec) begin
      if (cnt != C_CNT_MAX) begin
        v = cnt + C_CNT_ONE;
      end else begin
        v = cnt;
      end
    end else if (dec && !inc) begin
      v = cnt - C_CNT_ONE;
    end else begin
      v = cnt;
    end
    return v;
  endfunction

  // Next-state and next-output decode for the dispense sequencer.
  always_comb begin
    w_state_nxt       = r_state;
    w_rem_nxt         = r_remaining;
    w_gap_nxt         = r_gap;
    w_nickel_out_nxt  = 1'b0;
    w_dime_out_nxt    = 1'b0;
    w_quarter_out_nxt = 1'b0;
    w_done_nxt        = 1'b0;
    w_short_nxt       = 1'b0;
    w_ej_nickel       = 1'b0;
    w_ej_dime         = 1'b0;
    w_ej_quarter      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // req_ready is high throughout IDLE, so valid alone accepts.
        if (req_valid) begin
          w_rem_nxt   = req_amount;
          w_state_nxt = S_SELECT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SELECT: begin
        if ((r_remaining >= C_QUARTER) && (r_quarter_cnt != C_CNT_ZERO)) begin
          w_ej_quarter      = 1'b1;
          w_quarter_out_nxt = 1'b1;
          w_rem_nxt         = r_remaining - C_QUARTER;
          w_state_nxt       = S_DISPENSE;
        end else if ((r_remaining >= C_DIME) && (r_dime_cnt != C_CNT_ZERO)) begin
          w_ej_dime      = 1'b1;
          w_dime_out_nxt = 1'b1;
          w_rem_nxt      = r_remaining - C_DIME;
          w_state_nxt    = S_DISPENSE;
        end else if ((r_remaining >= C_NICKEL) && (r_nickel_cnt != C_CNT_ZERO)) begin
          w_ej_nickel      = 1'b1;
          w_nickel_out_nxt = 1'b1;
          w_rem_nxt        = r_remaining - C_NICKEL;
          w_state_nxt      = S_DISPENSE;
        end else begin
          w_done_nxt  = 1'b1;
          w_short_nxt = (r_remaining != C_AMT_ZERO);
          w_state_nxt = S_FINISH;
        end
      end
      S_DISPENSE: begin
        w_gap_nxt   = C_GAP;
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_gap <= 4'd1) begin
          w_gap_nxt   = 4'd0;
          w_state_nxt = S_SELECT;
        end else begin
          w_gap_nxt   = r_gap - 4'd1;
          w_state_nxt = S_GAP;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state, registered outputs and amount still owed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_remaining   <= C_AMT_ZERO;
      r_gap         <= 4'd0;
      r_nickel_out  <= 1'b0;
      r_dime_out    <= 1'b0;
      r_quarter_out <= 1'b0;
      r_done        <= 1'b0;
      r_short       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_remaining   <= w_rem_nxt;
      r_gap         <= w_gap_nxt;
      r_nickel_out  <= w_nickel_out_nxt;
      r_dime_out    <= w_dime_out_nxt;
      r_quarter_out <= w_quarter_out_nxt;
      r_done        <= w_done_nxt;
      r_short       <= w_short_nxt;
    end
  end

  // Coin inventory counters, updated in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nickel_cnt  <= C_CNT_ZERO;
      r_dime_cnt    <= C_CNT_ZERO;
      r_quarter_cnt <= C_CNT_ZERO;
    end else begin
      r_nickel_cnt  <= f_inv_next(r_nickel_cnt, nickel_in, w_ej_nickel);
      r_dime_cnt    <= f_inv_next(r_dime_cnt, dime_in, w_ej_dime);
      r_quarter_cnt <= f_inv_next(r_quarter_cnt, quarter_in, w_ej_quarter);
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign nickel_out  = r_nickel_out;
  assign dime_out    = r_dime_out;
  assign quarter_out = r_quarter_out;
  assign done        = r_done;
  assign short       = r_short;
  assign remaining   = r_remaining;
  assign nickel_cnt  = r_nickel_cnt;
  assign dime_cnt    = r_dime_cnt;
  assign quarter_cnt = r_quarter_cnt;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Bench for vm_change_dispenser: a transaction-schedule model of the coin
// return (greedy pick at each decision edge, fixed spacing between decisions)
// is compared with the DUT every cycle, plus directed literal expectations.
module tb_vm_change_dispenser;
  localparam int AMT_W = 9;
  localparam int CNT_W = 8;
  localparam int GAP   = 2;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             req_ready;
  logic             nickel_in = 1'b0;
  logic             dime_in = 1'b0;
  logic             quarter_in = 1'b0;
  logic             nickel_out, dime_out, quarter_out;
  logic             busy, done, short;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] nickel_cnt, dime_cnt, quarter_cnt;

  vm_change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
    .nickel_out(nickel_out), .dime_out(dime_out), .quarter_out(quarter_out),
    .busy(busy), .done(done), .short(short), .remaining(remaining),
    .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .quarter_cnt(quarter_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model: inventory, amount owed, and a schedule of decision edges.
  int m_q, m_d, m_n, m_rem, m_skip;
  bit m_busy, m_fin;
  bit e_qo, e_do, e_no, e_done, e_short;

  // Observation records for the directed literal checks.
  int acc_cyc, q_cyc, d_cyc, n_cyc, done_cyc, nq, nd, nn, ndone, done_rem;
  bit done_short;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_d = 0; m_n = 0; m_rem = 0; m_skip = 0;
    m_busy = 1'b0; m_fin = 1'b0;
    e_qo = 1'b0; e_do = 1'b0; e_no = 1'b0; e_done = 1'b0; e_short = 1'b0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input bit rv, input int amt, input bit ndp, input bit ddp, input bit qdp);
    int coin;
    int ejq, ejd, ejn;
    ejq = 0; ejd = 0; ejn = 0;
    e_qo = 1'b0; e_do = 1'b0; e_no = 1'b0; e_done = 1'b0; e_short = 1'b0;
    if (!m_busy) begin
      if (rv) begin
        m_busy = 1'b1; m_fin = 1'b0; m_rem = amt; m_skip = 0;
      end
    end else if (m_fin) begin
      m_busy = 1'b0; m_fin = 1'b0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else begin
      if (m_rem >= 25 && m_q > 0) coin = 25;
      else if (m_rem >= 10 && m_d > 0) coin = 10;
      else if (m_rem >= 5 && m_n > 0) coin = 5;
      else coin = 0;
      if (coin != 0) begin
        m_rem -= coin;
        m_skip = 1 + GAP;
        if (coin == 25) begin ejq = 1; e_qo = 1'b1; end
        if (coin == 10) begin ejd = 1; e_do = 1'b1; end
        if (coin == 5)  begin ejn = 1; e_no = 1'b1; end
      end else begin
        e_done = 1'b1; e_short = (m_rem != 0); m_fin = 1'b1;
      end
    end
    m_q = m_q + int'(qdp) - ejq; if (m_q > CMAX) m_q = CMAX;
    m_d = m_d + int'(ddp) - ejd; if (m_d > CMAX) m_d = CMAX;
    m_n = m_n + int'(ndp) - ejn; if (m_n > CMAX) m_n = CMAX;
  endtask

  task automatic compare_all();
    chk("req_ready", int'(req_ready), int'(!m_busy));
    chk("busy", int'(busy), int'(m_busy));
    chk("outs_done", int'({quarter_out, dime_out, nickel_out, done}), int'({e_qo, e_do, e_no, e_done}));
    chk("remaining", int'(remaining), m_rem);
    chk("counts", int'({quarter_cnt, dime_cnt, nickel_cnt}), (m_q << 16) | (m_d << 8) | m_n);
    if (e_done) chk("short", int'(short), int'(e_short));
  endtask

  task automatic clear_rec();
    q_cyc = -1; d_cyc = -1; n_cyc = -1; done_cyc = -1;
    nq = 0; nd = 0; nn = 0; ndone = 0; done_rem = -1; done_short = 1'b0;
  endtask

  task automatic record();
    if (quarter_out) begin nq++; if (q_cyc < 0) q_cyc = cyc; end
    if (dime_out)    begin nd++; if (d_cyc < 0) d_cyc = cyc; end
    if (nickel_out)  begin nn++; if (n_cyc < 0) n_cyc = cyc; end
    if (done) begin
      ndone++; done_cyc = cyc; done_short = short; done_rem = int'(remaining);
    end
  endtask

  // One cycle: check what the last edge produced, then drive the next edge.
  task automatic step(input bit rv, input int amt, input bit ndp, input bit ddp, input bit qdp);
    @(negedge clk);
    cyc++;
    compare_all();
    record();
    req_valid = rv; req_amount = AMT_W'(amt);
    nickel_in = ndp; dime_in = ddp; quarter_in = qdp;
    if (rv && !m_busy) acc_cyc = cyc;
    model_edge(rv, amt, ndp, ddp, qdp);
  endtask

  // Asynchronous reset applied away from the clock edge; effect is immediate.
  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    req_valid = 1'b0; nickel_in = 1'b0; dime_in = 1'b0; quarter_in = 1'b0;
    #1;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({quarter_out, dime_out, nickel_out, done, short}), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_counts", int'({quarter_cnt, dime_cnt, nickel_cnt}), 0);
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    model_edge(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic deposit(input int n, input bit ndp, input bit ddp, input bit qdp);
    for (int i = 0; i < n; i++) step(1'b0, 0, ndp, ddp, qdp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && m_busy; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    if (m_busy) chk("idle_timeout", 0, 1);
  endtask

  // Issue one request; optional dime deposits, held valid and abort offsets.
  task automatic run_req(input int amt, input int gap_dep, input int edge_dep, input int hold_k, input int abort_k);
    bit ddp;
    wait_idle();
    clear_rec();
    step(1'b1, amt, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 200; k++) begin
      if (k == abort_k) begin
        do_reset();
        return;
      end
      ddp = (k == gap_dep) || (k == edge_dep);
      step(k == hold_k, 99, 1'b0, ddp, 1'b0);
      if (k == hold_k) chk("ready_while_busy", int'(req_ready), 0);
      if (ndone > 0) break;
    end
    if (ndone == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    clear_rec();
    #1;
    chk("init_ready", int'(req_ready), 1);
    chk("init_counts", int'({quarter_cnt, dime_cnt, nickel_cnt}), 0);
    do_reset();

    // Two of each coin, 40 cents: quarter, dime, nickel, done.
    deposit(2, 1'b1, 1'b1, 1'b1);
    run_req(40, -1, -1, -1, -1);
    chk("s1_q_cyc", q_cyc - acc_cyc, 2);
    chk("s1_d_cyc", d_cyc - acc_cyc, 6);
    chk("s1_n_cyc", n_cyc - acc_cyc, 10);
    chk("s1_done_cyc", done_cyc - acc_cyc, 14);
    chk("s1_short", int'(done_short), 0);
    chk("s1_cnts", int'({quarter_cnt, dime_cnt, nickel_cnt}), 32'h010101);

    // Greedy without backtracking: q=1 d=3 n=0, 30 cents.
    do_reset();
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    deposit(2, 1'b0, 1'b1, 1'b0);
    run_req(30, -1, -1, -1, -1);
    chk("s2_nq", nq, 1);
    chk("s2_nd", nd, 0);
    chk("s2_short", int'(done_short), 1);
    chk("s2_rem", done_rem, 5);
    chk("s2_dcnt", int'(dime_cnt), 3);

    // Empty inventory, then amount 0.
    do_reset();
    run_req(15, -1, -1, -1, -1);
    chk("s3_done_cyc", done_cyc - acc_cyc, 2);
    chk("s3_short", int'(done_short), 1);
    chk("s3_rem", done_rem, 15);
    chk("s3_pulses", nq + nd + nn, 0);
    run_req(0, -1, -1, -1, -1);
    chk("s3_zero_short", int'(done_short), 0);
    chk("s3_zero_pulses", nq + nd + nn, 0);

    // Non-multiple of 5 with nickels only.
    do_reset();
    deposit(5, 1'b1, 1'b0, 1'b0);
    run_req(17, -1, -1, -1, -1);
    chk("s4_nn", nn, 3);
    chk("s4_short", int'(done_short), 1);
    chk("s4_rem", done_rem, 2);
    chk("s4_ncnt", int'(nickel_cnt), 2);

    // Dime deposits during GAP and on an eject edge; valid held while busy.
    do_reset();
    deposit(2, 1'b0, 1'b1, 1'b0);
    run_req(20, 3, 5, 2, -1);
    chk("s5_nd", nd, 2);
    chk("s5_dcnt", int'(dime_cnt), 2);
    chk("s5_short", int'(done_short), 0);
    chk("s5_rem", done_rem, 0);
    chk("s5_ndone", ndone, 1);

    // Reset during GAP drops the request; a fresh request then works.
    do_reset();
    deposit(2, 1'b0, 1'b0, 1'b1);
    run_req(50, -1, -1, -1, 3);
    chk("s6_nodone", ndone, 0);
    run_req(10, -1, -1, -1, -1);
    chk("s6_done_cyc", done_cyc - acc_cyc, 2);
    chk("s6_rem", done_rem, 10);
    chk("s6_short", int'(done_short), 1);

    // Saturation of a counter.
    do_reset();
    deposit(260, 1'b0, 1'b0, 1'b1);
    chk("sat_qcnt", int'(quarter_cnt), 255);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 7) == 0, int'($urandom_range(0, 140)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end
    wait_idle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
